fhe_op_scheduler: RTL and testbench
===================================

Name: fhe_op_scheduler

Overview:
- Sits between the Wishbone opcode-register decode (OPCODE_ADDR writes) and the LWE compute engine (encrypt/decrypt/add/multiply).
- Queues opcode words in a small command FIFO and issues them to the engine one at a time, using a start/done handshake.
- Guards each issued operation with a watchdog timeout.
- Exposes status, a completion counter and a completion interrupt pulse to firmware.

Parameters:
ADDR_WIDTH, 9, width of each operand/destination address field in the opcode word
QDEPTH, 4, command FIFO depth in entries (power of 2, >=2)
TIMEOUT_CYCLES, 1024, max cycles in BUSY before the watchdog fires
CNT_WIDTH, 16, width of the retired-operation counter

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  reset, asynchronous assert, active-low
cmd_we  in  1  one-cycle write strobe from the OPCODE_ADDR decode
cmd_data  in  32  opcode word: [1:0] op (00 enc, 01 dec, 10 add, 11 mul), [10:2] src_a, [19:11] src_b, [28:20] dst, [31] go
sw_flush  in  1  one-cycle pulse: discard all queued (not yet issued) commands
clr_err  in  1  one-cycle pulse: clear sticky error flags
eng_done  in  1  one-cycle pulse from the engine: operation complete
eng_start  out  1  one-cycle pulse: launch the operation on the eng_* fields
eng_op  out  2  opcode of the issued operation
eng_src_a  out  ADDR_WIDTH  operand A address
eng_src_b  out  ADDR_WIDTH  operand B address
eng_dst  out  ADDR_WIDTH  result address
eng_abort  out  1  one-cycle pulse on watchdog expiry
q_count  out  $clog2(QDEPTH)+1  entries currently queued
q_full  out  1  q_count == QDEPTH
busy  out  1  high in ISSUE or BUSY
done_irq  out  1  one-cycle pulse per retired operation
retired_cnt  out  CNT_WIDTH  operations completed since reset, wraps at 2^CNT_WIDTH
err_overflow  out  1  sticky: a go command was dropped because the queue was full
err_timeout  out  1  sticky: watchdog fired

Behaviour:
- Reset (wb_rst_ni=0, asynchronous):
  - FSM goes to IDLE and the FIFO is emptied.
  - All outputs are 0, including eng_* fields, retired_cnt and error flags.
- Enqueue:
  - A command enqueues when cmd_we=1, cmd_data[31]=1 and q_full=0. It is visible in q_count the next cycle.
  - cmd_we with bit31=0 is ignored silently.
  - cmd_we with bit31=1 while q_full=1 drops the command and sets err_overflow.
  - No enqueue-while-full, even if a pop happens in the same cycle.
- FSM states IDLE, ISSUE, BUSY, RETIRE:
  - IDLE: if q_count>0, go to ISSUE next cycle.
  - ISSUE (1 cycle):
    - eng_start=1.
    - eng_op/src_a/src_b/dst are registered from the FIFO head.
    - Pop the head.
    - The eng_* fields hold their values until the next ISSUE.
    - Watchdog counter is cleared. Next state is BUSY.
  - BUSY: watchdog increments each cycle.
    - eng_done=1: go to RETIRE.
    - Else if the counter reaches TIMEOUT_CYCLES-1: eng_abort=1 for one cycle, err_timeout set, go to IDLE. No done_irq, no count.
    - eng_done and watchdog terminal count in the same cycle: done wins.
  - RETIRE (1 cycle): done_irq=1, retired_cnt+1. Next state IDLE.
- Issue latency:
  - Enqueue into an empty queue while IDLE gives eng_start 2 cycles after the cmd_we cycle.
  - Back-to-back commands: next eng_start 2 cycles after RETIRE.
- Outside BUSY: eng_done is ignored.
- sw_flush:
  - Sets q_count to 0 next cycle and has no effect on the in-flight operation.
  - Flush coincident with an enqueue: flush wins, and the command is dropped without flagging overflow.
  - Flush coincident with the ISSUE pop: the issued command still proceeds.
- clr_err clears both sticky flags. If an error event occurs in the same cycle, set wins.
- FIFO pointers wrap modulo QDEPTH. q_count is exact across wrap.

Test Plan:
- Single add:
  - Stimulus: cmd_we with cmd_data=0x83232002 (op=10, src_a=0, src_b=100, dst=50) in IDLE.
  - Response: eng_start 2 cycles later with eng_op=2, src_a=0, src_b=100, dst=50.
  - Then eng_done 5 cycles later: done_irq one cycle after eng_done, retired_cnt=1, busy=0.
- Queue fill/overflow:
  - Stimulus: with the engine stalled (no eng_done), write 6 go-commands in consecutive cycles.
  - Response: 1 issued, q_count reaches 4 with q_full=1, err_overflow=1. Remaining commands issue in FIFO order after done pulses.
- Go-bit clear:
  - Stimulus: cmd_data=0x03232002 with cmd_we.
  - Response: q_count stays 0, no eng_start, no error.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=16, issue one command, never assert eng_done.
  - Response: eng_abort pulse on the 16th BUSY cycle, err_timeout=1, retired_cnt unchanged, next queued command issues.
  - Then: clr_err clears the flag.
- Done vs timeout collision:
  - Stimulus: assert eng_done on the terminal watchdog cycle.
  - Response: RETIRE taken, done_irq=1, no eng_abort, err_timeout=0.
- Flush and async reset:
  - Stimulus: queue 3 commands while BUSY, pulse sw_flush.
  - Response: q_count=0, in-flight operation retires normally.
  - Then: drop wb_rst_ni mid-BUSY. All outputs are 0 immediately (without waiting for a clock edge), FSM is in IDLE after release.

Source files
------------

// File: rtl/fhe_op_scheduler.sv
// Opcode command queue and single-issue scheduler for the LWE compute engine,
// with a per-operation watchdog, retired-operation counter and sticky error flags.
module fhe_op_scheduler #(
    parameter int unsigned ADDR_WIDTH     = 9,
    parameter int unsigned QDEPTH         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic                      cmd_we,
    input  logic [31:0]               cmd_data,
    input  logic                      sw_flush,
    input  logic                      clr_err,
    input  logic                      eng_done,
    output logic                      eng_start,
    output logic [1:0]                eng_op,
    output logic [ADDR_WIDTH-1:0]     eng_src_a,
    output logic [ADDR_WIDTH-1:0]     eng_src_b,
    output logic [ADDR_WIDTH-1:0]     eng_dst,
    output logic                      eng_abort,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      q_full,
    output logic                      busy,
    output logic                      done_irq,
    output logic [CNT_WIDTH-1:0]      retired_cnt,
    output logic                      err_overflow,
    output logic                      err_timeout
);
    localparam int unsigned PTR_W   = $clog2(QDEPTH);
    localparam int unsigned CNT_Q_W = PTR_W + 1;
    localparam int unsigned ENTRY_W = 2 + 3 * ADDR_WIDTH;
    localparam int unsigned WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_Q_W-1:0] Q_FULL_CNT = CNT_Q_W'(QDEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RETIRE} state_t;

    state_t               state, state_nxt;
    logic [ENTRY_W-1:0]   mem [QDEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_Q_W-1:0]   cnt_nxt;
    logic [WD_W-1:0]      wd;
    logic                 go_cmd, push, ovf_evt, pop, load;
    logic                 wd_clr, wd_inc, abort_nxt;
    logic                 unused_bits;

    assign unused_bits = ^cmd_data[30:ENTRY_W];

    // Flush beats a coincident enqueue, which is then neither stored nor flagged.
    assign go_cmd  = cmd_we & cmd_data[31];
    assign push    = go_cmd & ~q_full & ~sw_flush;
    assign ovf_evt = go_cmd & q_full & ~sw_flush;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state <= IDLE;
        else            state <= state_nxt;
    end

    // Lifecycle of one operation; eng_done beats the watchdog terminal count.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        wd_clr    = 1'b0;
        wd_inc    = 1'b0;
        abort_nxt = 1'b0;
        case (state)
            IDLE: begin
                if ((q_count != '0) && !sw_flush) state_nxt = ISSUE;
            end
            ISSUE: begin
                pop       = ~sw_flush;
                wd_clr    = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: begin
                if (eng_done) begin
                    state_nxt = RETIRE;
                end else if (wd == WD_LAST) begin
                    abort_nxt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            RETIRE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign load = (state == IDLE) && (state_nxt == ISSUE);

    always_comb begin
        cnt_nxt = q_count;
        if (push && !pop)      cnt_nxt = q_count + CNT_Q_W'(1);
        else if (pop && !push) cnt_nxt = q_count - CNT_Q_W'(1);
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= cmd_data[ENTRY_W-1:0];
    end

    // Pointers wrap naturally because QDEPTH is a power of two.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
            q_full  <= 1'b0;
        end else if (sw_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
            q_full  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            q_count <= cnt_nxt;
            q_full  <= (cnt_nxt == Q_FULL_CNT);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)  wd <= '0;
        else if (wd_clr) wd <= '0;
        else if (wd_inc) wd <= wd + WD_W'(1);
    end

    // Engine-facing outputs line up with the state they describe.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            eng_start   <= 1'b0;
            eng_abort   <= 1'b0;
            busy        <= 1'b0;
            done_irq    <= 1'b0;
            retired_cnt <= '0;
            eng_op      <= '0;
            eng_src_a   <= '0;
            eng_src_b   <= '0;
            eng_dst     <= '0;
        end else begin
            eng_start <= (state_nxt == ISSUE);
            eng_abort <= abort_nxt;
            busy      <= (state_nxt == ISSUE) || (state_nxt == BUSY);
            done_irq  <= (state_nxt == RETIRE);
            if (state_nxt == RETIRE) retired_cnt <= retired_cnt + CNT_WIDTH'(1);
            if (load) {eng_dst, eng_src_b, eng_src_a, eng_op} <= mem[rd_ptr];
        end
    end

    // Sticky error flags: a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            if (ovf_evt)      err_overflow <= 1'b1;
            else if (clr_err) err_overflow <= 1'b0;
            if (abort_nxt)    err_timeout  <= 1'b1;
            else if (clr_err) err_timeout  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fhe_op_scheduler.sv
// Self-checking bench for fhe_op_scheduler: directed table, corner-case sequences,
// and randomized traffic against a queue-based lifecycle model.
module tb_fhe_op_scheduler;
    localparam int unsigned AW = 9;
    localparam int unsigned QD = 4;
    localparam int unsigned TO = 16;
    localparam int unsigned CW = 16;
    localparam int PH_IDLE = 0, PH_ISSUE = 1, PH_BUSY = 2, PH_RETIRE = 3;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_ni = 1'b0;
    logic          cmd_we = 1'b0;
    logic [31:0]   cmd_data = '0;
    logic          sw_flush = 1'b0;
    logic          clr_err = 1'b0;
    logic          eng_done = 1'b0;
    logic          eng_start, eng_abort, q_full, busy, done_irq, err_overflow, err_timeout;
    logic [1:0]    eng_op;
    logic [AW-1:0] eng_src_a, eng_src_b, eng_dst;
    logic [2:0]    q_count;
    logic [CW-1:0] retired_cnt;

    fhe_op_scheduler #(.ADDR_WIDTH(AW), .QDEPTH(QD), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .cmd_we(cmd_we), .cmd_data(cmd_data),
        .sw_flush(sw_flush), .clr_err(clr_err), .eng_done(eng_done), .eng_start(eng_start),
        .eng_op(eng_op), .eng_src_a(eng_src_a), .eng_src_b(eng_src_b), .eng_dst(eng_dst),
        .eng_abort(eng_abort), .q_count(q_count), .q_full(q_full), .busy(busy),
        .done_irq(done_irq), .retired_cnt(retired_cnt), .err_overflow(err_overflow),
        .err_timeout(err_timeout)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model: a command queue plus the lifecycle of the one operation in flight.
    logic [28:0]   mq[$];
    int            m_phase;
    int            m_age;
    bit            m_start, m_abort, m_irq, m_ovf, m_to;
    logic [28:0]   m_head;
    logic [CW-1:0] m_cnt;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic logic [31:0] mkcmd(input int op, input int a, input int b, input int d, input bit go);
        return {go, 2'b00, 9'(d), 9'(b), 9'(a), 2'(op)};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_phase = PH_IDLE; m_age = 0;
        m_start = 0; m_abort = 0; m_irq = 0; m_ovf = 0; m_to = 0;
        m_head = '0; m_cnt = '0;
    endtask

    task automatic model_step(input bit we, input logic [31:0] d, input bit fl, input bit cl, input bit dn);
        bit full, go, ovf_ev, to_ev, do_pop;
        full   = (mq.size() == QD);
        go     = we && d[31];
        ovf_ev = go && full && !fl;
        to_ev  = 0;
        do_pop = 0;
        m_start = 0; m_abort = 0; m_irq = 0;
        case (m_phase)
            PH_IDLE: if (mq.size() != 0 && !fl) begin
                m_phase = PH_ISSUE; m_start = 1; m_head = mq[0];
            end
            PH_ISSUE: begin
                do_pop = !fl; m_phase = PH_BUSY; m_age = 1;
            end
            PH_BUSY: begin
                if (dn) begin
                    m_phase = PH_RETIRE; m_irq = 1; m_cnt = m_cnt + 16'd1;
                end else if (m_age == TO) begin
                    m_abort = 1; to_ev = 1; m_phase = PH_IDLE;
                end else begin
                    m_age++;
                end
            end
            default: m_phase = PH_IDLE;
        endcase
        if (fl) mq.delete();
        else begin
            if (do_pop) void'(mq.pop_front());
            if (go && !full) mq.push_back(d[28:0]);
        end
        if (ovf_ev) m_ovf = 1; else if (cl) m_ovf = 0;
        if (to_ev)  m_to = 1;  else if (cl) m_to = 0;
    endtask

    task automatic check_all();
        chk("eng_start", 32'(eng_start), 32'(m_start));
        chk("eng_abort", 32'(eng_abort), 32'(m_abort));
        chk("done_irq", 32'(done_irq), 32'(m_irq));
        chk("busy", 32'(busy), 32'(m_phase == PH_ISSUE || m_phase == PH_BUSY));
        chk("q_count", 32'(q_count), 32'(mq.size()));
        chk("q_full", 32'(q_full), 32'(mq.size() == QD));
        chk("retired_cnt", 32'(retired_cnt), 32'(m_cnt));
        chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
        chk("err_timeout", 32'(err_timeout), 32'(m_to));
        chk("eng_fields", 32'({eng_dst, eng_src_b, eng_src_a, eng_op}), 32'(m_head));
    endtask

    task automatic tick(input bit we, input logic [31:0] d, input bit fl, input bit cl, input bit dn);
        cmd_we = we; cmd_data = d; sw_flush = fl; clr_err = cl; eng_done = dn;
        @(posedge wb_clk_i);
        model_step(we, d, fl, cl, dn);
        cyc++;
        #1;
        check_all();
    endtask

    task automatic tick_idle();
        tick(0, 32'h0, 0, 0, 0);
    endtask

    task automatic wait_start(input string tag);
        for (int i = 0; i < 10 && !eng_start; i++) tick_idle();
        chk(tag, 32'(eng_start), 32'd1);
    endtask

    typedef struct {
        bit          we;
        logic [31:0] data;
        bit          dn;
        bit          e_start;
        bit          e_busy;
        bit          e_irq;
        int          e_q;
        int          e_cnt;
        bit          e_ovf;
    } vec_t;
    vec_t vq[$];

    task automatic add_vec(input bit we, input logic [31:0] data, input bit dn, input bit st,
                           input bit bz, input bit irq, input int q, input int cnt, input bit ovf);
        vec_t v;
        v.we = we; v.data = data; v.dn = dn; v.e_start = st; v.e_busy = bz;
        v.e_irq = irq; v.e_q = q; v.e_cnt = cnt; v.e_ovf = ovf;
        vq.push_back(v);
    endtask

    logic [31:0] cmds[6];
    int          starts;
    int          t_start;
    logic [CW-1:0] cnt_before;

    initial begin
        // Single add then an ignored go-less write: eng_start two cycles after cmd_we,
        // eng_done five cycles after eng_start, done_irq in the following cycle.
        add_vec(1, 32'h83232002, 0, 0, 0, 0, 1, 0, 0);
        add_vec(0, 32'h0,        0, 1, 1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) add_vec(0, 32'h0, 0, 0, 1, 0, 0, 0, 0);
        add_vec(0, 32'h0,        1, 0, 0, 1, 0, 1, 0);
        add_vec(0, 32'h0,        0, 0, 0, 0, 0, 1, 0);
        add_vec(1, 32'h03232002, 0, 0, 0, 0, 0, 1, 0);
        add_vec(0, 32'h0,        0, 0, 0, 0, 0, 1, 0);
        add_vec(0, 32'h0,        0, 0, 0, 0, 0, 1, 0);

        model_reset();
        repeat (2) @(posedge wb_clk_i);
        #1;
        check_all();
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;

        foreach (vq[i]) begin
            tick(vq[i].we, vq[i].data, 0, 0, vq[i].dn);
            chk($sformatf("tbl%0d_start", i), 32'(eng_start), 32'(vq[i].e_start));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vq[i].e_busy));
            chk($sformatf("tbl%0d_irq", i), 32'(done_irq), 32'(vq[i].e_irq));
            chk($sformatf("tbl%0d_qcount", i), 32'(q_count), 32'(vq[i].e_q));
            chk($sformatf("tbl%0d_retired", i), 32'(retired_cnt), 32'(vq[i].e_cnt));
            chk($sformatf("tbl%0d_ovf", i), 32'(err_overflow), 32'(vq[i].e_ovf));
            if (vq[i].e_start)
                chk($sformatf("tbl%0d_fields", i), 32'({eng_dst, eng_src_b, eng_src_a, eng_op}),
                    32'({9'd50, 9'd100, 9'd0, 2'd2}));
        end

        // Fill and overflow with the engine stalled; survivors issue in FIFO order.
        for (int i = 0; i < 6; i++) cmds[i] = mkcmd(i % 4, i + 1, i + 10, i + 20, 1);
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1, cmds[i], 0, 0, 0);
            if (eng_start) starts++;
        end
        chk("ovf_starts", 32'(starts), 32'd1);
        chk("ovf_qcount", 32'(q_count), 32'd4);
        chk("ovf_qfull", 32'(q_full), 32'd1);
        chk("ovf_flag", 32'(err_overflow), 32'd1);
        tick(0, 32'h0, 0, 0, 1);
        for (int k = 1; k <= 4; k++) begin
            wait_start($sformatf("fifo%0d_start", k));
            chk($sformatf("fifo%0d_fields", k), 32'({eng_dst, eng_src_b, eng_src_a, eng_op}),
                32'(cmds[k][28:0]));
            tick_idle();
            tick(0, 32'h0, 0, 0, 1);
        end
        tick(0, 32'h0, 0, 1, 0);
        chk("ovf_cleared", 32'(err_overflow), 32'd0);

        // Watchdog: abort pulse right after the 16th BUSY cycle, then next command issues.
        cnt_before = retired_cnt;
        tick(1, mkcmd(3, 7, 8, 9, 1), 0, 0, 0);
        tick(1, mkcmd(1, 11, 12, 13, 1), 0, 0, 0);
        chk("wd_first_start", 32'(eng_start), 32'd1);
        t_start = cyc;
        for (int i = 0; i < 40 && !eng_abort; i++) tick_idle();
        chk("wd_abort_seen", 32'(eng_abort), 32'd1);
        chk("wd_abort_latency", 32'(cyc - t_start), 32'(TO + 1));
        chk("wd_err_timeout", 32'(err_timeout), 32'd1);
        chk("wd_retired_same", 32'(retired_cnt), 32'(cnt_before));
        tick_idle();
        chk("wd_next_start", 32'(eng_start), 32'd1);
        chk("wd_next_fields", 32'({eng_dst, eng_src_b, eng_src_a, eng_op}),
            32'({9'd13, 9'd12, 9'd11, 2'd1}));

        // Clear the flag, then complete exactly on the terminal watchdog cycle.
        tick_idle();
        tick(0, 32'h0, 0, 1, 0);
        chk("clr_timeout", 32'(err_timeout), 32'd0);
        for (int i = 0; i < 14; i++) tick_idle();
        tick(0, 32'h0, 0, 0, 1);
        chk("coll_irq", 32'(done_irq), 32'd1);
        chk("coll_abort", 32'(eng_abort), 32'd0);
        chk("coll_timeout", 32'(err_timeout), 32'd0);
        chk("coll_retired", 32'(retired_cnt), 32'(cnt_before + 16'd1));
        tick_idle();
        chk("coll_no_late_abort", 32'(eng_abort), 32'd0);

        // Flush while busy: queue emptied, in-flight operation still retires.
        tick(1, mkcmd(0, 1, 2, 3, 1), 0, 0, 0);
        wait_start("fl_start");
        for (int i = 0; i < 3; i++) tick(1, mkcmd(2, i, i, i, 1), 0, 0, 0);
        chk("fl_q3", 32'(q_count), 32'd3);
        tick(0, 32'h0, 1, 0, 0);
        chk("fl_q0", 32'(q_count), 32'd0);
        chk("fl_busy", 32'(busy), 32'd1);
        cnt_before = retired_cnt;
        tick(0, 32'h0, 0, 0, 1);
        chk("fl_irq", 32'(done_irq), 32'd1);
        chk("fl_retired", 32'(retired_cnt), 32'(cnt_before + 16'd1));
        repeat (3) tick_idle();

        // Asynchronous reset mid-BUSY: outputs clear between clock edges.
        tick(1, mkcmd(3, 5, 6, 7, 1), 1'b0, 1'b0, 1'b0);
        tick(1, mkcmd(1, 5, 6, 7, 1), 1'b0, 1'b0, 1'b0);
        tick_idle();
        tick_idle();
        chk("rst_pre_busy", 32'(busy), 32'd1);
        #2;
        wb_rst_ni = 1'b0;
        #1;
        chk("rst_start", 32'(eng_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_qcount", 32'(q_count), 32'd0);
        chk("rst_qfull", 32'(q_full), 32'd0);
        chk("rst_retired", 32'(retired_cnt), 32'd0);
        chk("rst_errs", 32'({err_overflow, err_timeout, eng_abort, done_irq}), 32'd0);
        chk("rst_fields", 32'({eng_dst, eng_src_b, eng_src_a, eng_op}), 32'd0);
        model_reset();
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        repeat (3) tick_idle();
        tick(1, mkcmd(2, 1, 1, 1, 1), 0, 0, 0);
        tick_idle();
        chk("post_rst_start", 32'(eng_start), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] d;
            d = $urandom;
            d[31] = ($urandom_range(0, 3) != 0);
            tick($urandom_range(0, 1) == 1, d, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
